// File: rtl/sjr_caller_pkg.sv
// Shared types and defaults for the method-call initiator (sjr_method_caller).
package sjr_caller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FREE,
    REQ,
    RUN,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ACK_TO  = 2'd1,
    ERR_RUN_TO  = 2'd2,
    ERR_BAD_IDX = 2'd3
  } err_t;

  localparam int DEF_N_METHODS   = 4;
  localparam int DEF_IDX_W       = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_ACK_TIMEOUT = 64;
  localparam int DEF_RUN_TIMEOUT = 4096;

  // Bits needed to count up to the larger of two timeouts.
  function automatic int to_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sjr_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module sjr_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sjr_method_caller.sv
// Initiator for the <method>_req/<method>_busy handshake; one call in flight.
// Timeout enforcement is built only when SJR_CALLER_TIMEOUT_EN is defined.
module sjr_method_caller
  import sjr_caller_pkg::*;
#(
  parameter int N_METHODS   = DEF_N_METHODS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IDX_W-1:0]     cmd_method,
  output logic [N_METHODS-1:0] method_req,
  input  logic [N_METHODS-1:0] method_busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDX_W-1:0]     rsp_method,
  output logic [CNT_W-1:0]     rsp_cycles,
  output logic [1:0]           rsp_err
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             busy_sel;
  logic [CNT_W-1:0] cyc;
  logic             cyc_en;
  logic             ack_to;
  logic             run_to;

  always_comb begin
    busy_sel = 1'b0;
    for (int unsigned i = 0; i < N_METHODS; i++) begin
      if (idx == IDX_W'(i)) busy_sel = method_busy[i];
    end
  end

  // Loaded to 1 on the edge that enters REQ, so it equals cycles spent in REQ+RUN.
  assign cyc_en = ((state == WAIT_FREE) && !busy_sel) || (state == REQ) || (state == RUN);

  sjr_sat_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .reset (reset),
    .clr   (state == IDLE),
    .en    (cyc_en),
    .cnt   (cyc)
  );

`ifdef SJR_CALLER_TIMEOUT_EN
  localparam int TO_W = to_width(ACK_TIMEOUT, RUN_TIMEOUT);

  logic [TO_W-1:0] tcnt;
  logic            to_clr;

  // Restarts at the REQ->RUN edge, so it holds (cycles in current phase - 1).
  assign to_clr = !((state == REQ) || (state == RUN)) || ((state == REQ) && busy_sel);

  sjr_sat_counter #(.W(TO_W)) u_to (
    .clk   (clk),
    .reset (reset),
    .clr   (to_clr),
    .en    (1'b1),
    .cnt   (tcnt)
  );

  assign ack_to = (tcnt >= TO_W'(ACK_TIMEOUT - 1));
  assign run_to = (tcnt >= TO_W'(RUN_TIMEOUT - 1));
`else
  localparam int unused_timeouts = ACK_TIMEOUT + RUN_TIMEOUT;

  assign ack_to = 1'b0;
  assign run_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      cmd_ready  <= 1'b0;
      method_req <= '0;
      rsp_valid  <= 1'b0;
      rsp_method <= '0;
      rsp_cycles <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            idx       <= cmd_method;
            if ({1'b0, cmd_method} >= (IDX_W + 1)'(N_METHODS)) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_method <= cmd_method;
              rsp_cycles <= '0;
              rsp_err    <= ERR_BAD_IDX;
            end else begin
              state <= WAIT_FREE;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WAIT_FREE: begin
          if (!busy_sel) begin
            state      <= REQ;
            method_req <= N_METHODS'(1) << idx;
          end
        end
        REQ: begin
          if (busy_sel) begin
            method_req <= '0;
            state      <= RUN;
          end else if (ack_to) begin
            method_req <= '0;
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_method <= idx;
            rsp_cycles <= cyc;
            rsp_err    <= ERR_ACK_TO;
          end
        end
        RUN: begin
          if (!busy_sel || run_to) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_method <= idx;
            rsp_cycles <= cyc;
            rsp_err    <= busy_sel ? ERR_RUN_TO : ERR_OK;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          method_req <= '0;
          rsp_valid  <= 1'b0;
          cmd_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sjr_method_caller.sv
// Self-checking bench for sjr_method_caller; follows SJR_CALLER_TIMEOUT_EN if defined.
module tb_sjr_method_caller;

  localparam int NM      = 3;
  localparam int ACK     = 8;
  localparam int RUNTO   = 32;
  localparam int CNT_MAX = 15;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_method;
  logic [2:0] method_req;
  logic [2:0] method_busy;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_method;
  logic [3:0] rsp_cycles;
  logic [1:0] rsp_err;

  int checks = 0;
  int errors = 0;

  sjr_method_caller #(
    .N_METHODS   (NM),
    .IDX_W       (2),
    .CNT_W       (4),
    .ACK_TIMEOUT (ACK),
    .RUN_TIMEOUT (RUNTO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_method  (cmd_method),
    .method_req  (method_req),
    .method_busy (method_busy),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_method  (rsp_method),
    .rsp_cycles  (rsp_cycles),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: callee raises busy d cycles after req is seen and holds it h cycles.
  function automatic void ref_call(input int m, input int d, input int h,
                                   output int exp_req, output int exp_err, output int exp_cyc);
    int run;
    if (m >= NM) begin
      exp_req = 0; exp_err = 3; exp_cyc = 0;
      return;
    end
    exp_req = d + 1;
    run     = h;
    exp_err = 0;
`ifdef SJR_CALLER_TIMEOUT_EN
    if (d + 1 > ACK) begin
      exp_req = ACK; run = 0; exp_err = 1;
    end else if (h > RUNTO) begin
      run = RUNTO; exp_err = 2;
    end
`endif
    exp_cyc = exp_req + run;
    if (exp_cyc > CNT_MAX) exp_cyc = CNT_MAX;
  endfunction

  task automatic run_call(input int m, input int d, input int h, input int pre,
                          input bit rand_others, input int limit, input int abort_after,
                          output int req_cnt, output bit got_rsp, output int viol,
                          output int waited, output int rsp_at,
                          output logic [1:0] o_meth, output logic [1:0] o_err,
                          output logic [3:0] o_cyc);
    int first_req, hold_left, pre_left;
    bit raised;
    logic [2:0] mask;
    req_cnt = 0; got_rsp = 0; viol = 0; waited = 0; rsp_at = -1;
    o_meth = '0; o_err = '0; o_cyc = '0;
    first_req = -1; raised = 0; hold_left = 0; pre_left = pre;
    mask = 3'b001 << m;
    rsp_ready = 1'b0;
    if (pre > 0) method_busy[m] = 1'b1;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      viol++;
      return;
    end
    cmd_valid  = 1'b1;
    cmd_method = 2'(m);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cmd_valid = 1'b0;
        if (cmd_ready) viol++;
      end
      if (rand_others)
        for (int j = 0; j < NM; j++) if (j != m) method_busy[j] = 1'($urandom_range(0, 1));
      if ((method_req & ~mask) != 3'b000) viol++;
      if (m < NM && method_req[m]) begin
        req_cnt++;
        if (first_req < 0) first_req = c;
      end
      if (pre_left > 0) begin
        if (method_req != 3'b000) viol++;
        pre_left--;
        if (pre_left == 0) method_busy[m] = 1'b0;
      end
      if (first_req >= 0 && !raised && (c - first_req) == d) begin
        method_busy[m] = 1'b1;
        raised = 1;
        hold_left = h;
      end else if (raised && hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) method_busy[m] = 1'b0;
      end
      if (rsp_valid) begin
        got_rsp = 1; rsp_at = c;
        o_meth = rsp_method; o_err = rsp_err; o_cyc = rsp_cycles;
        break;
      end
      if (abort_after >= 0 && c == abort_after) break;
    end
    method_busy = '0;
  endtask

  task automatic consume(output logic v_after, output logic r_after);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    v_after = rsp_valid;
    r_after = cmd_ready;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_method = '0; method_busy = '0; rsp_ready = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (method_req !== 3'b000) begin errors++; $display("FAIL reset_req: got %b expected 000", method_req); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({rsp_method, rsp_cycles, rsp_err} !== 8'h00) begin errors++; $display("FAIL reset_rsp_fields: got %h expected 00", {rsp_method, rsp_cycles, rsp_err}); end
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL release_cmd_ready_early: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic check_call(input string name, input int m, input int d, input int h, input int pre,
                            input bit rand_others);
    int req_cnt, viol, waited, rsp_at, er, ee, ec;
    bit got;
    logic [1:0] om, oe;
    logic [3:0] oc;
    logic va, ra;
    ref_call(m, d, h, er, ee, ec);
    run_call(m, d, h, pre, rand_others, 200, -1, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL %s_rsp_seen: got %b expected 1", name, got); end
    checks++; if (viol != 0) begin errors++; $display("FAIL %s_protocol: got %0d violations expected 0", name, viol); end
    checks++; if (req_cnt != er) begin errors++; $display("FAIL %s_req_cycles: got %0d expected %0d", name, req_cnt, er); end
    checks++; if (om !== 2'(m)) begin errors++; $display("FAIL %s_rsp_method: got %0d expected %0d", name, om, m); end
    checks++; if (oe !== 2'(ee)) begin errors++; $display("FAIL %s_rsp_err: got %0d expected %0d", name, oe, ee); end
    checks++; if (oc !== 4'(ec)) begin errors++; $display("FAIL %s_rsp_cycles: got %0d expected %0d", name, oc, ec); end
    consume(va, ra);
    checks++; if ({va, ra} !== 2'b01) begin errors++; $display("FAIL %s_consume: got valid=%b ready=%b expected valid=0 ready=1", name, va, ra); end
  endtask

  task automatic test_normal_call();
    check_call("normal", 1, 1, 5, 0, 1'b1);
  endtask

  task automatic test_busy_already_high();
    check_call("prebusy", 0, 1, 5, 10, 1'b0);
  endtask

  task automatic test_bad_index();
    int req_cnt, viol, waited, rsp_at;
    bit got;
    logic [1:0] om, oe;
    logic [3:0] oc;
    logic va, ra;
    run_call(3, 1, 1, 0, 1'b1, 20, -1, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
    checks++; if (!(got && rsp_at == 0)) begin errors++; $display("FAIL badidx_rsp_time: got seen=%b at=%0d expected seen=1 at=0", got, rsp_at); end
    checks++; if (req_cnt != 0 || viol != 0) begin errors++; $display("FAIL badidx_no_req: got req=%0d viol=%0d expected 0 0", req_cnt, viol); end
    checks++; if ({om, oe, oc} !== {2'd3, 2'd3, 4'd0}) begin errors++; $display("FAIL badidx_fields: got m=%0d e=%0d c=%0d expected 3 3 0", om, oe, oc); end
    consume(va, ra);
  endtask

  task automatic test_no_answer();
    int req_cnt, viol, waited, rsp_at;
    bit got;
    logic [1:0] om, oe;
    logic [3:0] oc;
    logic va, ra;
`ifdef SJR_CALLER_TIMEOUT_EN
    run_call(2, 1000000, 1, 0, 1'b0, 100, -1, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
    checks++; if (req_cnt != ACK) begin errors++; $display("FAIL ackto_req_cycles: got %0d expected %0d", req_cnt, ACK); end
    checks++; if (!(got && oe === 2'd1 && oc === 4'(ACK))) begin errors++; $display("FAIL ackto_rsp: got seen=%b err=%0d cyc=%0d expected 1 1 %0d", got, oe, oc, ACK); end
    consume(va, ra);
`else
    run_call(2, 1000000, 1, 0, 1'b0, 1000, -1, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
    checks++; if (got !== 1'b0) begin errors++; $display("FAIL noack_no_rsp: got rsp=%b expected 0", got); end
    checks++; if (req_cnt != 999 || method_req !== 3'b100) begin errors++; $display("FAIL noack_req_held: got cnt=%0d req=%b expected 999 100", req_cnt, method_req); end
    do_reset();
`endif
  endtask

  task automatic test_boundaries();
    check_call("ack_edge", 2, ACK - 1, 3, 0, 1'b0);
    check_call("run_edge", 0, 0, RUNTO, 0, 1'b0);
    check_call("run_over", 1, 0, RUNTO + 1, 0, 1'b0);
    check_call("saturate", 1, 2, 20, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    int req_cnt, viol, waited, rsp_at, unstable;
    bit got;
    logic [1:0] om, oe;
    logic [3:0] oc;
    logic va, ra;
    run_call(2, 0, 3, 0, 1'b0, 100, -1, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
    checks++; if (!(got && om === 2'd2 && oe === 2'd0 && oc === 4'd4)) begin errors++; $display("FAIL bp_first_rsp: got m=%0d e=%0d c=%0d expected 2 0 4", om, oe, oc); end
    cmd_valid = 1'b1; cmd_method = 2'd3;
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || {rsp_method, rsp_err, rsp_cycles} !== {om, oe, oc}) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if ({cmd_ready, rsp_valid, rsp_err} !== {1'b0, 1'b1, 2'd3}) begin errors++; $display("FAIL bp_next_accept: got ready=%b valid=%b err=%0d expected 0 1 3", cmd_ready, rsp_valid, rsp_err); end
    consume(va, ra);
  endtask

  task automatic test_back_to_back();
    int req_cnt, viol, waited, rsp_at;
    bit got;
    logic [1:0] om, oe;
    logic [3:0] oc;
    logic va, ra;
    for (int k = 0; k < 2; k++) begin
      run_call(k, 0, 2, 0, 1'b0, 100, -1, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
      checks++; if (waited != 0 || !got || oc !== 4'd3) begin errors++; $display("FAIL b2b_call%0d: got waited=%0d seen=%b cyc=%0d expected 0 1 3", k, waited, got, oc); end
      consume(va, ra);
    end
  endtask

  task automatic test_random();
    int m, d, h;
    for (int k = 0; k < 12; k++) begin
      m = $urandom_range(0, 3);
      d = $urandom_range(0, 10);
      h = $urandom_range(1, 40);
      check_call($sformatf("rand%0d", k), m, d, h, $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_reset_mid_run();
    int req_cnt, viol, waited, rsp_at;
    bit got;
    logic [1:0] om, oe;
    logic [3:0] oc;
    run_call(1, 1, 50, 0, 1'b0, 100, 6, req_cnt, got, viol, waited, rsp_at, om, oe, oc);
    checks++; if (req_cnt != 2 || got) begin errors++; $display("FAIL midrun_setup: got req=%0d rsp=%b expected 2 0", req_cnt, got); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({method_req, rsp_valid, cmd_ready} !== 5'b00000) begin errors++; $display("FAIL midrun_async: got req=%b valid=%b ready=%b expected 000 0 0", method_req, rsp_valid, cmd_ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL midrun_ready_early: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL midrun_recover: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_normal_call();
    test_no_answer();
    test_busy_already_high();
    test_bad_index();
    test_backpressure();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
